// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing the write port of one enable/reset data register.
// Grant, owner and busy are registered; REG_D/REG_ENABLE follow combinationally.
module reg_share_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                   CLK,
    input  logic                   RES,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] DATA,
    output logic [N_REQ-1:0]       GNT,
    output logic [2:0]             OWNER,
    output logic                   BUSY,
    output logic [WIDTH-1:0]       REG_D,
    output logic                   REG_ENABLE
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic              busy_q, busy_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;

    logic [N_REQ-1:0]  others;
    logic              search;
    logic [N_REQ-1:0]  search_mask;
    logic [IDX_W-1:0]  search_start;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [WIDTH-1:0]  data_arr [N_REQ];

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_LAST) ? '0 : idx + 1'b1;
    endfunction

    // First set bit of mask at or after start, wrapping modulo N_REQ; MSB flags a hit.
    function automatic logic [IDX_W:0] rr_search(input logic [N_REQ-1:0] mask,
                                                 input logic [IDX_W-1:0] start);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        int               j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(start) + i;
            if (j >= N_REQ) j = j - N_REQ;
            cand = IDX_W'(j);
            if (!found && mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    assign others = REQ & ~gnt_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        busy_d       = busy_q;
        hold_d       = hold_q;
        ptr_d        = ptr_q;
        search       = 1'b0;
        search_mask  = REQ;
        search_start = ptr_q;

        case (state_q)
            IDLE: begin
                search       = 1'b1;
                search_mask  = REQ;
                search_start = ptr_q;
            end
            GRANTED: begin
                // Owner released, or it has used its hold budget while someone waits.
                if (!REQ[owner_q] || (others != '0 && hold_q == HOLD_LAST)) begin
                    search       = 1'b1;
                    search_mask  = others;
                    search_start = next_idx(owner_q);
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        {pick_found, pick_idx} = rr_search(search_mask, search_start);

        if (search) begin
            if (pick_found) begin
                state_d         = GRANTED;
                gnt_d           = '0;
                gnt_d[pick_idx] = 1'b1;
                owner_d         = pick_idx;
                busy_d          = 1'b1;
                hold_d          = '0;
                ptr_d           = next_idx(pick_idx);
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
                owner_d = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign data_arr[i] = DATA[i*WIDTH +: WIDTH];
    end

    assign GNT        = gnt_q;
    assign OWNER      = 3'(owner_q);
    assign BUSY       = busy_q;
    assign REG_ENABLE = |(gnt_q & REQ);
    assign REG_D      = busy_q ? data_arr[owner_q] : '0;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: a cycle model predicts outputs and writes,
// a negedge monitor compares them, and directed phases pin the key grant sequences.
module tb_reg_share_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int MH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*W-1:0] data_bus;
    logic [NR-1:0]   gnt;
    logic [2:0]      owner;
    logic            busy;
    logic [W-1:0]    reg_d;
    logic            reg_en;
    logic [W-1:0]    data_v [NR];

    assign data_bus = {data_v[3], data_v[2], data_v[1], data_v[0]};

    reg_share_arbiter #(.N_REQ(NR), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .CLK        (clk),
        .RES        (rst),
        .REQ        (req),
        .DATA       (data_bus),
        .GNT        (gnt),
        .OWNER      (owner),
        .BUSY       (busy),
        .REG_D      (reg_d),
        .REG_ENABLE (reg_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] gnt;
        logic [2:0]    owner;
        logic          busy;
        logic          en;
        logic [W-1:0]  d;
    } exp_t;

    exp_t         out_q[$];
    logic [W-1:0] wr_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           wr_cnt [NR];
    logic [W-1:0] shadow_reg = '0;

    // Model state: owner index (-1 when idle), hold counter, round-robin pointer.
    int m_owner = -1;
    int m_hold  = 0;
    int m_ptr   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int find_next(input logic [NR-1:0] m, input int start);
        for (int i = 0; i < NR; i++) begin
            int j;
            j = (start + i) % NR;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [NR-1:0] r);
        logic [NR-1:0] oth;
        int            pick;
        logic          do_search;
        do_search = 1'b0;
        pick      = -1;
        if (m_owner < 0) begin
            pick      = find_next(r, m_ptr);
            do_search = 1'b1;
        end else begin
            oth          = r;
            oth[m_owner] = 1'b0;
            if (!r[m_owner] || (oth != 0 && m_hold == MH - 1)) begin
                pick      = find_next(oth, m_owner + 1);
                do_search = 1'b1;
            end else if (m_hold < MH - 1) begin
                m_hold++;
            end
        end
        if (do_search) begin
            if (pick >= 0) begin
                m_owner = pick;
                m_hold  = 0;
                m_ptr   = (pick + 1) % NR;
            end else begin
                m_owner = -1;
                m_hold  = 0;
            end
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
    endfunction

    // Drive one cycle of REQ, queue the expected outputs/write, advance the model at the edge.
    task automatic step(input logic [NR-1:0] r);
        exp_t e;
        req     = r;
        e.busy  = (m_owner >= 0);
        e.gnt   = e.busy ? (NR'(1) << m_owner) : '0;
        e.owner = e.busy ? 3'(m_owner) : 3'd0;
        e.en    = e.busy && r[m_owner];
        e.d     = e.busy ? data_v[m_owner] : '0;
        out_q.push_back(e);
        if (e.en) wr_q.push_back(e.d);
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_q.size() > 0) begin
            e = out_q.pop_front();
            check("gnt", gnt, e.gnt);
            check("owner", owner, e.owner);
            check("busy", busy, e.busy);
            check("reg_en", reg_en, e.en);
            check("reg_d", reg_d, e.d);
        end
        if (!rst && reg_en) begin
            wr_cnt[owner] = wr_cnt[owner] + 1;
            shadow_reg    = reg_d;
            if (wr_q.size() == 0) check("wr_unexpected", reg_en, 1'b0);
            else check("wr_data", reg_d, wr_q.pop_front());
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int          ord [5];
        logic [NR-1:0] prev;
        ord = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NR; i++) begin
            data_v[i] = 32'h1000_0001 * (i + 1);
            wr_cnt[i] = 0;
        end
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_owner", owner, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_reg_en", reg_en, 1'b0);
        check("rst_reg_d", reg_d, 32'h0);

        // Asynchronous reset in the middle of a granted cycle.
        step(4'b0010);
        check("pre_rst_gnt", gnt, 4'b0010);
        #2 rst = 1'b1;
        #1;
        check("async_rst_gnt", gnt, 4'b0000);
        check("async_rst_en", reg_en, 1'b0);
        check("async_rst_d", reg_d, 32'h0);
        out_q.delete();
        wr_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        step(4'b0010);
        check("post_rst_gnt", gnt, 4'b0010);
        check("post_rst_owner", owner, 3'd1);
        step(4'b0000);

        // Single writer: three writes of DEADBEEF, grant drops one edge after REQ.
        data_v[2] = 32'hDEAD_BEEF;
        for (int i = 0; i < NR; i++) wr_cnt[i] = 0;
        step(4'b0100);
        check("single_gnt", gnt, 4'b0100);
        repeat (3) step(4'b0100);
        step(4'b0000);
        check("single_release_gnt", gnt, 4'b0000);
        check("single_writes", wr_cnt[2], 3);
        check("single_reg_value", shadow_reg, 32'hDEAD_BEEF);

        // Park the pointer at 0, then check the fairness order.
        step(4'b1000);
        step(4'b0000);
        step(4'b1111);
        for (int k = 0; k < 5; k++) begin
            check("rr_owner", owner, 3'(ord[k]));
            check("rr_gnt", gnt, NR'(1) << ord[k]);
            step(4'b1111);
            step(4'b1111 & ~(NR'(1) << ord[k]));
        end
        step(4'b0000);

        // Hold limit: owner 0 keeps 4 cycles, then requester 3 is forced in.
        for (int i = 0; i < NR; i++) wr_cnt[i] = 0;
        step(4'b0001);
        check("hold_first_gnt", gnt, 4'b0001);
        step(4'b0001);
        repeat (3) step(4'b1001);
        check("hold_rotate_gnt", gnt, 4'b1000);
        check("hold_writes", wr_cnt[0], 4);
        step(4'b0000);

        // Handover without a bubble cycle.
        step(4'b0010);
        check("handover_pre_gnt", gnt, 4'b0010);
        step(4'b0110);
        step(4'b0100);
        check("handover_gnt", gnt, 4'b0100);
        step(4'b0100);
        step(4'b0000);

        // Release and new requests in the same cycle, pointer at 1.
        step(4'b0001);
        check("swap_first_gnt", gnt, 4'b0001);
        step(4'b0001);
        step(4'b1010);
        check("swap_gnt", gnt, 4'b0010);
        step(4'b0000);

        // Random traffic against the model.
        prev = '0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) prev = NR'($urandom);
            if ($urandom_range(0, 7) == 0) data_v[$urandom_range(0, NR - 1)] = $urandom;
            step(prev);
        end
        step(4'b0000);
        step(4'b0000);
        check("out_q_drained", out_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin arbiter that shares the write side of one 32-bit enable/reset data register among N_REQ requesters (e.g. ALU writeback, load unit, CSR/debug path).
- Drives the register's D and ENABLE inputs.
- Guarantees exactly one writer per cycle.
- Bounds how long any requester can hold the register while others are waiting.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, data width of each requester and of the shared register.
- MAX_HOLD, 4, maximum consecutive granted cycles while another requester is pending (>=1).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RES  input  1  asynchronous, active-high reset.
- REQ  input  N_REQ  per-requester write request, level.
- DATA  input  N_REQ*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- GNT  output  N_REQ  one-hot grant, registered.
- OWNER  output  3  binary index of current grant holder; 0 when idle.
- BUSY  output  1  1 when any GNT bit is set.
- REG_D  output  WIDTH  data to shared register D input.
- REG_ENABLE  output  1  write enable to shared register.

Behaviour:
- Reset (RES=1, asynchronous): GNT=0, OWNER=0, BUSY=0, hold counter=0, round-robin pointer=0. REG_ENABLE=0 and REG_D=0 follow combinationally. Applying reset mid-grant drops the grant immediately with no further write.
- States:
  - IDLE: GNT=0.
  - GRANTED: exactly one GNT bit set.
- Arbitration at each rising edge; the search starts at pointer p and goes upward modulo N_REQ:
  - IDLE with any REQ set: grant the first set REQ at or after p, then go to GRANTED. Hold counter=0.
  - IDLE with no REQ: stay IDLE.
  - GRANTED, owner g, REQ[g]=0: re-arbitrate in the same edge among the other requesters, starting at g+1; go to IDLE if none are set. No bubble cycle.
  - GRANTED, REQ[g]=1, no other REQ set: keep the grant. Hold counter saturates at MAX_HOLD-1.
  - GRANTED, REQ[g]=1, another REQ set, counter<MAX_HOLD-1: keep the grant and increment the counter.
  - GRANTED, REQ[g]=1, another REQ set, counter==MAX_HOLD-1: forced rotation to the next set REQ after g. Counter resets.
- Pointer update: on every new grant to index k, p becomes (k+1) mod N_REQ.
- Latency: a REQ rising in cycle n is granted at the edge ending cycle n at the earliest, so GNT is visible in cycle n+1.
- Datapath (combinational from registered GNT and live inputs):
  - REG_ENABLE = |(GNT & REQ).
  - REG_D = DATA slice of OWNER when BUSY, else 0.
- The shared register captures REG_D at the same edge at which REG_ENABLE is high, so each granted cycle with REQ still high yields one write.
- A requester that drops REQ while granted gets no write in that cycle, because REG_ENABLE=0.
- OWNER and BUSY are registered alongside GNT and always consistent with it.
- Requesters at index >= N_REQ do not exist. OWNER never exceeds N_REQ-1.

Test Plan:
- Reset/idle: assert RES asynchronously mid-cycle with REQ=4'b0010 held -> GNT=0, REG_ENABLE=0, REG_D=0 immediately. After release, GNT=4'b0010 one edge later and OWNER=1.
- Single writer: REQ=4'b0100, DATA[2]=32'hDEADBEEF for 3 cycles -> GNT=4'b0100 from cycle 1. REG_ENABLE=1 for 3 cycles. Register holds 32'hDEADBEEF. GNT=0 one edge after REQ drops.
- Round-robin fairness: REQ=4'b1111, each requester drops REQ after its first granted cycle and re-asserts the next cycle -> grant order 0,1,2,3,0. No index granted twice before all others.
- Hold limit: MAX_HOLD=4, REQ[0] held continuously, REQ[3] asserted in cycle 2 of owner 0's grant -> owner 0 keeps the grant 4 cycles total, then GNT=4'b1000. Exactly 4 writes of DATA[0].
- Handover without bubble: owner 1 drops REQ while REQ[2]=1 -> GNT changes 4'b0010->4'b0100 at the same edge. REG_ENABLE=0 for that one cycle only, then writes DATA[2].
- Simultaneous release and new requests: REQ goes from 4'b0001 to 4'b1010 in one cycle, pointer=1 -> GNT=4'b0010 next edge, not 4'b1000.
